// File: rtl/gpu_pkg.sv
// Shared GPU core types: scheduler state encoding, writeback source select
// and the fixed register map of a thread's register file.
package gpu_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    FETCH   = 3'd1,
    DECODE  = 3'd2,
    REQUEST = 3'd3,
    WAIT    = 3'd4,
    EXECUTE = 3'd5,
    UPDATE  = 3'd6,
    DONE    = 3'd7
  } core_state_t;

  typedef enum logic [1:0] {
    REG_SRC_ALU   = 2'b00,
    REG_SRC_MEM   = 2'b01,
    REG_SRC_CONST = 2'b10
  } reg_src_t;

  localparam int REG_BLOCK_IDX  = 13;
  localparam int REG_BLOCK_DIM  = 14;
  localparam int REG_THREAD_IDX = 15;
  localparam int NUM_REGS       = 16;

endpackage

// File: rtl/thread_regfile.sv
// Per-thread register file: 13 GPRs plus read-only block/thread identity
// registers, with registered operand reads and gated writeback.
module thread_regfile
  import gpu_pkg::*;
#(
  parameter int THREAD_ID         = 0,
  parameter int THREADS_PER_BLOCK = 4,
  parameter int DATA_BITS         = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 enable,
  input  logic [2:0]           core_state,
  input  logic [7:0]           block_id,
  input  logic [3:0]           rd_addr,
  input  logic [3:0]           rs_addr,
  input  logic [3:0]           rt_addr,
  input  logic                 reg_write_en,
  input  logic [1:0]           reg_input_mux,
  input  logic [DATA_BITS-1:0] alu_out,
  input  logic [DATA_BITS-1:0] lsu_out,
  input  logic [DATA_BITS-1:0] immediate,
  output logic [DATA_BITS-1:0] rs_data,
  output logic [DATA_BITS-1:0] rt_data
);

  logic [DATA_BITS-1:0] regs [NUM_REGS];
  logic [DATA_BITS-1:0] wr_data;
  logic                 wr_src_ok;
  logic                 wr_go;

  always_comb begin
    wr_data   = '0;
    wr_src_ok = 1'b1;
    case (reg_input_mux)
      REG_SRC_ALU:   wr_data = alu_out;
      REG_SRC_MEM:   wr_data = lsu_out;
      REG_SRC_CONST: wr_data = immediate;
      default:       wr_src_ok = 1'b0;
    endcase
  end

  // Identity registers (R13-R15) are never targets of writeback.
  assign wr_go = (core_state == UPDATE) && reg_write_en && wr_src_ok &&
                 (rd_addr < 4'(REG_BLOCK_IDX));

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < REG_BLOCK_DIM; i++) regs[i] <= '0;
      regs[REG_BLOCK_DIM]  <= DATA_BITS'(THREADS_PER_BLOCK);
      regs[REG_THREAD_IDX] <= DATA_BITS'(THREAD_ID);
      rs_data              <= '0;
      rt_data              <= '0;
    end else if (enable) begin
      regs[REG_BLOCK_IDX] <= DATA_BITS'(block_id);
      if (core_state == REQUEST) begin
        rs_data <= regs[rs_addr];
        rt_data <= regs[rt_addr];
      end
      if (wr_go) regs[rd_addr] <= wr_data;
    end
  end

endmodule

// File: doc/thread_regfile.md
# thread_regfile

Per-thread register file for the GPU compute core. Holds sixteen 8-bit registers: thirteen general-purpose, plus three read-only registers carrying block and thread identity. It sits directly upstream of the ALU, supplying its A/B operands, and receives writeback from the ALU, the LSU or the decoded immediate. All reads and writes are gated by the core's shared execution state, so one instance per thread lane advances in lockstep with the core scheduler.

## Interface
Parameters:
- THREAD_ID, 0, lane index of this thread; reset value of R15.
- THREADS_PER_BLOCK, 4, reset value of R14.
- DATA_BITS, 8, register width.

Ports:
- clk  input  1  core clock; all state updates on its rising edge.
- reset  input  1  synchronous, active-high.
- enable  input  1  lane active in current block; low freezes all state.
- core_state  input  3  scheduler state (core_state_t).
- block_id  input  8  current block index, mirrored into R13.
- rd_addr  input  4  destination register index.
- rs_addr  input  4  source register index for operand A.
- rt_addr  input  4  source register index for operand B.
- reg_write_en  input  1  decoded write enable.
- reg_input_mux  input  2  writeback source select (reg_src_t).
- alu_out  input  8  ALU result.
- lsu_out  input  8  LSU load data.
- immediate  input  8  decoded constant.
- rs_data  output  8  registered operand A, to the ALU A input.
- rt_data  output  8  registered operand B, to the ALU B input.

## Operation
- core_state encoding: IDLE=0, FETCH=1, DECODE=2, REQUEST=3, WAIT=4, EXECUTE=5, UPDATE=6, DONE=7.
- Register map:
  - R0–R12 are general-purpose.
  - R13 is %blockIdx.
  - R14 is %blockDim.
  - R15 is %threadIdx.
- Reset (reset=1 at a rising edge, regardless of enable or state):
  - R0–R12 = 0.
  - R13 = 0.
  - R14 = THREADS_PER_BLOCK.
  - R15 = THREAD_ID.
  - rs_data = 0 and rt_data = 0.
- When enable=0: no register or output changes, including R13.
- When enable=1, on every edge: R13 <= block_id.
- Read: when core_state==REQUEST, rs_data <= R[rs_addr] and rt_data <= R[rt_addr]. Both outputs hold their values in all other states.
- Write: when core_state==UPDATE, reg_write_en=1 and rd_addr<13, R[rd_addr] <= the source selected by reg_input_mux:
  - ALU (2'b00) = alu_out.
  - MEM (2'b01) = lsu_out.
  - CONST (2'b10) = immediate.
  - 2'b11 = no write.
- Writes with rd_addr 13–15 are silently dropped; those registers keep their values.
- Write data is truncated or stored as-is at DATA_BITS; there is no sign handling.
- Reads and writes never coincide, because REQUEST and UPDATE are distinct states. No bypass path is required.
- rs_addr == rt_addr is legal; both outputs return the same value.

## Timing
- Read latency is one cycle: rs_data/rt_data are valid the cycle after the edge that samples REQUEST. They stay stable through WAIT, EXECUTE and UPDATE, so the ALU sees constant operands.
- Write latency is one cycle: the register updates at the edge sampling UPDATE, and the new value is visible to the next REQUEST read.
- The R13 mirror lags block_id by one edge.
- Reset mid-instruction, in any state, takes priority over both read and write on that edge.
- No combinational path from inputs to outputs.

## Structure
- Shared package gpu_pkg contains:
  - core_state_t: 3-bit enum with the encoding above.
  - reg_src_t: 2-bit enum with values REG_SRC_ALU, REG_SRC_MEM, REG_SRC_CONST.
  - Localparams REG_BLOCK_IDX=13, REG_BLOCK_DIM=14, REG_THREAD_IDX=15, NUM_REGS=16.
- No sub-module: one register array, a write-decode block and a registered read mux.

## Test plan
- Reset with THREAD_ID=2, THREADS_PER_BLOCK=4; REQUEST with rs=14, rt=15 -> rs_data=4, rt_data=2; R0 read -> 0.
- UPDATE with rd=3, mux=CONST, immediate=8'h5A, write_en=1; then REQUEST with rs=3 -> rs_data=8'h5A one cycle after REQUEST.
- UPDATE with rd=15, mux=ALU, alu_out=8'hFF -> subsequent read of R15 still returns THREAD_ID; R0–R12 unchanged.
- enable=0, UPDATE with rd=1, immediate=7 and block_id=9 -> R1 stays 0 and R13 stays 0; with enable=1 and block_id=9 -> R13 reads 9.
- REQUEST loads rs_data=8'h5A, then alu_out and state toggle through WAIT/EXECUTE -> rs_data holds 8'h5A until the next REQUEST; mux=2'b11 in UPDATE -> no register changes.
- Assert reset during UPDATE with write_en=1, rd=2 -> R2=0, rs_data=0, rt_data=0 on the following cycle.
